reuleaux_seq: RTL and testbench

Sequencer and pixel-mask stage paired with the `circle` drawer. It takes a Reuleaux-triangle centre and diameter and computes the three vertex centres. It drives `circle` three times, once per vertex, through circle's reset, start and done handshake. It passes through only those circle pixels that lie on that vertex's arc, and the gated pixel stream goes to the VGA adapter.

---
 rtl/reuleaux_pkg.sv | 25 ++
 rtl/reuleaux_vertex.sv | 59 +++++
 rtl/reuleaux_seq.sv | 190 +++++++++++++++++++
 tb/tb_reuleaux_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reuleaux_pkg.sv
// Shared types and constants for the Reuleaux-triangle sequencer.
// The optional arc mask is selected by the REULEAUX_ARC_MASK_EN macro in reuleaux_seq.sv.
package reuleaux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_ARC_RST = 3'd2,
        ST_ARC_RUN = 3'd3,
        ST_DONE    = 3'd4
    } reuleaux_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int DEF_SQRT3_6_NUM = 74;
    localparam int DEF_FRAC_BITS   = 8;

    typedef logic signed [9:0] scoord_t;

    function automatic logic coord_ok(input scoord_t v, input scoord_t lim);
        return (v >= 10'sd0) && (v < lim);
    endfunction

endpackage

// File: rtl/reuleaux_vertex.sv
// Combinational vertex geometry: three arc centres of a Reuleaux triangle plus an on-screen check.
// Coordinates are narrowed to screen width on output; they are only meaningful when in_range_o is 1.
module reuleaux_vertex
    import reuleaux_pkg::*;
#(
    parameter int SQRT3_6_NUM = DEF_SQRT3_6_NUM,
    parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
    input  logic [7:0] centre_x_i,
    input  logic [6:0] centre_y_i,
    input  logic [7:0] diameter_i,
    output logic [7:0] v0_x_o,
    output logic [6:0] v0_y_o,
    output logic [7:0] v1_x_o,
    output logic [6:0] v1_y_o,
    output logic [7:0] v2_x_o,
    output logic [6:0] v2_y_o,
    output logic       in_range_o
);

    localparam scoord_t W_LIM = scoord_t'(SCREEN_W);
    localparam scoord_t H_LIM = scoord_t'(SCREEN_H);

    logic [17:0] prod;
    logic [17:0] prod_sh;
    scoord_t     h6, h3, cx, cy, half;
    scoord_t     v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;

    assign prod    = 18'(diameter_i) * 18'(SQRT3_6_NUM);
    assign prod_sh = prod >> FRAC_BITS;
    assign h6      = $signed(prod_sh[9:0]);
    assign h3      = h6 + h6;

    assign cx   = $signed({2'b00, centre_x_i});
    assign cy   = $signed({3'b000, centre_y_i});
    assign half = $signed({3'b000, diameter_i[7:1]});

    assign v0_x = cx;
    assign v0_y = cy - h3;
    assign v1_x = cx - half;
    assign v1_y = cy + h6;
    assign v2_x = cx + half;
    assign v2_y = cy + h6;

    // Upper bits of each coordinate are consumed here, so only the range check sees them.
    assign in_range_o = (diameter_i >= 8'd2)
                      && coord_ok(v0_x, W_LIM) && coord_ok(v0_y, H_LIM)
                      && coord_ok(v1_x, W_LIM) && coord_ok(v1_y, H_LIM)
                      && coord_ok(v2_x, W_LIM) && coord_ok(v2_y, H_LIM)
                      && (prod_sh[17:10] == 8'd0);

    assign v0_x_o = v0_x[7:0];
    assign v0_y_o = v0_y[6:0];
    assign v1_x_o = v1_x[7:0];
    assign v1_y_o = v1_y[6:0];
    assign v2_x_o = v2_x[7:0];
    assign v2_y_o = v2_y[6:0];

endmodule

// File: rtl/reuleaux_seq.sv
// Reuleaux-triangle sequencer: drives the circle drawer once per vertex and masks its pixels to one arc each.
// Define REULEAUX_ARC_MASK_EN to apply the arc mask; otherwise full circles are forwarded.
module reuleaux_seq
    import reuleaux_pkg::*;
#(
    parameter int SQRT3_6_NUM = DEF_SQRT3_6_NUM,
    parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] diameter,
    input  logic [2:0] colour,
    output logic       done,
    output logic       err,
    output logic       circ_rst_n,
    output logic       circ_start,
    output logic [7:0] circ_centre_x,
    output logic [6:0] circ_centre_y,
    output logic [7:0] circ_radius,
    input  logic       circ_done,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    reuleaux_state_t state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [7:0]      cx_q, cx_d;
    logic [6:0]      cy_q, cy_d;
    logic [7:0]      d_q, d_d;
    logic [2:0]      colour_q, colour_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic [2:0][7:0] vx_q, vx_d;
    logic [2:0][6:0] vy_q, vy_d;

    logic [7:0] nv0_x, nv1_x, nv2_x;
    logic [6:0] nv0_y, nv1_y, nv2_y;
    logic       in_range;
    logic       arc_mask;

    reuleaux_vertex #(
        .SQRT3_6_NUM (SQRT3_6_NUM),
        .FRAC_BITS   (FRAC_BITS)
    ) u_vertex (
        .centre_x_i (cx_q),
        .centre_y_i (cy_q),
        .diameter_i (d_q),
        .v0_x_o     (nv0_x),
        .v0_y_o     (nv0_y),
        .v1_x_o     (nv1_x),
        .v1_y_o     (nv1_y),
        .v2_x_o     (nv2_x),
        .v2_y_o     (nv2_y),
        .in_range_o (in_range)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= 2'd0;
            cx_q     <= '0;
            cy_q     <= '0;
            d_q      <= '0;
            colour_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            vx_q     <= '0;
            vy_q     <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            d_q      <= d_d;
            colour_q <= colour_d;
            err_q    <= err_d;
            done_q   <= done_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
        end
    end

    // A low start outside IDLE/DONE aborts the drawing; that check outranks circ_done.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        d_d      = d_q;
        colour_d = colour_q;
        err_d    = err_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        done_d   = (state_q == ST_DONE) && start;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CALC;
                    cx_d     = centre_x;
                    cy_d     = centre_y;
                    d_d      = diameter;
                    colour_d = colour;
                    err_d    = 1'b0;
                    k_d      = 2'd0;
                end
            end
            ST_CALC: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (!in_range) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_ARC_RST;
                    k_d     = 2'd0;
                    vx_d    = {nv2_x, nv1_x, nv0_x};
                    vy_d    = {nv2_y, nv1_y, nv0_y};
                end
            end
            ST_ARC_RST: begin
                state_d = start ? ST_ARC_RUN : ST_IDLE;
            end
            ST_ARC_RUN: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (circ_done) begin
                    if (k_q == 2'd2) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARC_RST;
                        k_d     = k_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef REULEAUX_ARC_MASK_EN
    // Each vertex circle keeps only the arc facing the opposite edge of the triangle.
    always_comb begin
        arc_mask = 1'b0;
        case (k_q)
            2'd0:    arc_mask = (circ_y >= vy_q[1]);
            2'd1:    arc_mask = (circ_x >= cx_q) && (circ_y <= vy_q[1]);
            2'd2:    arc_mask = (circ_x <= cx_q) && (circ_y <= vy_q[2]);
            default: arc_mask = 1'b0;
        endcase
    end
`else
    assign arc_mask = 1'b1;
`endif

    always_comb begin
        circ_centre_x = 8'd0;
        circ_centre_y = 7'd0;
        case (k_q)
            2'd0: begin circ_centre_x = vx_q[0]; circ_centre_y = vy_q[0]; end
            2'd1: begin circ_centre_x = vx_q[1]; circ_centre_y = vy_q[1]; end
            2'd2: begin circ_centre_x = vx_q[2]; circ_centre_y = vy_q[2]; end
            default: begin circ_centre_x = 8'd0; circ_centre_y = 7'd0; end
        endcase
    end

    assign circ_rst_n  = !((state_q == ST_IDLE) || (state_q == ST_CALC) || (state_q == ST_ARC_RST));
    assign circ_start  = (state_q == ST_ARC_RUN);
    assign circ_radius = d_q;

    assign done = done_q;
    assign err  = err_q;

    // The circ_done cycle carries no pixel, so it is suppressed even if circ_plot is high.
    assign vga_plot   = circ_plot && (state_q == ST_ARC_RUN) && !circ_done && arc_mask;
    assign vga_x      = circ_x;
    assign vga_y      = circ_y;
    assign vga_colour = colour_q;

endmodule

// File: tb/tb_reuleaux_seq.sv
// Directed bench for reuleaux_seq: the circle drawer is played by the bench through circ_* inputs.
module tb_reuleaux_seq;

`ifdef REULEAUX_ARC_MASK_EN
    localparam logic MASK_EN = 1'b1;
`else
    localparam logic MASK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] diameter;
    logic [2:0] colour;
    logic       done, err, circ_rst_n, circ_start;
    logic [7:0] circ_centre_x, circ_radius;
    logic [6:0] circ_centre_y;
    logic       circ_done;
    logic [7:0] circ_x;
    logic [6:0] circ_y;
    logic       circ_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int checks = 0;
    int errors = 0;

    reuleaux_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .centre_x      (centre_x),
        .centre_y      (centre_y),
        .diameter      (diameter),
        .colour        (colour),
        .done          (done),
        .err           (err),
        .circ_rst_n    (circ_rst_n),
        .circ_start    (circ_start),
        .circ_centre_x (circ_centre_x),
        .circ_centre_y (circ_centre_y),
        .circ_radius   (circ_radius),
        .circ_done     (circ_done),
        .circ_x        (circ_x),
        .circ_y        (circ_y),
        .circ_plot     (circ_plot),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic [7:0] x, input logic [6:0] y, input logic [7:0] d, input logic [2:0] c);
        centre_x = x;
        centre_y = y;
        diameter = d;
        colour   = c;
    endtask

    task automatic pixel(input logic [7:0] x, input logic [6:0] y, input logic p, input logic dn);
        circ_x    = x;
        circ_y    = y;
        circ_plot = p;
        circ_done = dn;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_centre(input string tag, input logic [7:0] x, input logic [6:0] y);
        chk({tag, "_cx"}, 32'(circ_centre_x), 32'(x));
        chk({tag, "_cy"}, 32'(circ_centre_y), 32'(y));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_crst"}, 32'(circ_rst_n), 0);
        chk({tag, "_cstart"}, 32'(circ_start), 0);
        chk({tag, "_plot"}, 32'(vga_plot), 0);
        chk({tag, "_radius"}, 32'(circ_radius), 0);
        chk({tag, "_colour"}, 32'(vga_colour), 0);
        chk_centre(tag, 8'd0, 7'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_req(8'd0, 7'd0, 8'd0, 3'd0);
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        pixel(8'd5, 7'd5, 1'b1, 1'b0);
        chk_reset_outputs("rst");
        pixel(8'd0, 7'd0, 1'b0, 1'b0);

        // Full draw: centre (80,60), d=80 -> V0 (80,14), V1 (40,83), V2 (120,83)
        set_req(8'd80, 7'd60, 8'd80, 3'd5);
        start = 1'b1;
        step();
        chk("calc_err", 32'(err), 0);
        chk("calc_crst", 32'(circ_rst_n), 0);
        chk("calc_cstart", 32'(circ_start), 0);
        step();
        chk("k0rst_crst", 32'(circ_rst_n), 0);
        chk("k0rst_cstart", 32'(circ_start), 0);
        chk_centre("k0rst", 8'd80, 7'd14);
        chk("k0rst_radius", 32'(circ_radius), 80);
        step();
        chk("k0run_crst", 32'(circ_rst_n), 1);
        chk("k0run_cstart", 32'(circ_start), 1);
        chk_centre("k0run", 8'd80, 7'd14);
        pixel(8'd80, 7'd94, 1'b1, 1'b0);
        chk("k0_p94_plot", 32'(vga_plot), 1);
        chk("k0_p94_x", 32'(vga_x), 80);
        chk("k0_p94_y", 32'(vga_y), 94);
        chk("k0_colour", 32'(vga_colour), 5);
        pixel(8'd80, 7'd71, 1'b1, 1'b0);
        chk("k0_p71_plot", 32'(vga_plot), MASK_EN ? 0 : 1);
        pixel(8'd80, 7'd83, 1'b1, 1'b0);
        chk("k0_p83_plot", 32'(vga_plot), 1);
        pixel(8'd80, 7'd82, 1'b1, 1'b0);
        chk("k0_p82_plot", 32'(vga_plot), MASK_EN ? 0 : 1);
        pixel(8'd80, 7'd94, 1'b0, 1'b0);
        chk("k0_noplot", 32'(vga_plot), 0);
        pixel(8'd80, 7'd94, 1'b1, 1'b1);
        chk("k0_done_plot", 32'(vga_plot), 0);
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        chk("k1rst_crst", 32'(circ_rst_n), 0);
        chk_centre("k1rst", 8'd40, 7'd83);
        step();
        chk("k1run_cstart", 32'(circ_start), 1);
        pixel(8'd60, 7'd50, 1'b1, 1'b0);
        chk("k1_p60_plot", 32'(vga_plot), MASK_EN ? 0 : 1);
        pixel(8'd100, 7'd50, 1'b1, 1'b0);
        chk("k1_p100_plot", 32'(vga_plot), 1);
        pixel(8'd80, 7'd83, 1'b1, 1'b0);
        chk("k1_edge_plot", 32'(vga_plot), 1);
        pixel(8'd100, 7'd84, 1'b1, 1'b0);
        chk("k1_low_plot", 32'(vga_plot), MASK_EN ? 0 : 1);
        pixel(8'd0, 7'd0, 1'b0, 1'b1);
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        chk_centre("k2rst", 8'd120, 7'd83);
        step();
        chk("k2run_cstart", 32'(circ_start), 1);
        pixel(8'd60, 7'd50, 1'b1, 1'b0);
        chk("k2_p60_plot", 32'(vga_plot), 1);
        pixel(8'd100, 7'd50, 1'b1, 1'b0);
        chk("k2_p100_plot", 32'(vga_plot), MASK_EN ? 0 : 1);
        chk("k2_done_early", 32'(done), 0);
        pixel(8'd0, 7'd0, 1'b0, 1'b1);
        step();
        pixel(8'd60, 7'd50, 1'b1, 1'b0);
        chk("done0_done", 32'(done), 0);
        chk("done0_cstart", 32'(circ_start), 0);
        chk("done0_crst", 32'(circ_rst_n), 1);
        chk("done0_plot", 32'(vga_plot), 0);
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        chk("done1_done", 32'(done), 1);
        chk("done1_err", 32'(err), 0);
        step();
        chk("done2_done", 32'(done), 1);
        start = 1'b0;
        step();
        chk("idle_done", 32'(done), 0);
        chk("idle_crst", 32'(circ_rst_n), 0);

        // Off-screen: centre (10,60), d=80 -> V1.x = -30
        set_req(8'd10, 7'd60, 8'd80, 3'd3);
        start = 1'b1;
        step();
        pixel(8'd10, 7'd10, 1'b1, 1'b0);
        chk("rej_calc_cstart", 32'(circ_start), 0);
        chk("rej_calc_plot", 32'(vga_plot), 0);
        step();
        chk("rej_err", 32'(err), 1);
        chk("rej_cstart", 32'(circ_start), 0);
        chk("rej_plot", 32'(vga_plot), 0);
        step();
        chk("rej_done", 32'(done), 1);
        chk("rej_plot2", 32'(vga_plot), 0);
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        start = 1'b0;
        step();
        chk("rej_idle_done", 32'(done), 0);
        chk("rej_idle_err", 32'(err), 1);

        // Degenerate diameter, then a valid request clears err
        set_req(8'd80, 7'd60, 8'd1, 3'd1);
        start = 1'b1;
        step();
        step();
        chk("d1_err", 32'(err), 1);
        chk("d1_cstart", 32'(circ_start), 0);
        start = 1'b0;
        step();
        set_req(8'd80, 7'd60, 8'd80, 3'd6);
        start = 1'b1;
        step();
        chk("retry_calc_err", 32'(err), 0);
        step();
        chk_centre("retry_k0rst", 8'd80, 7'd14);
        step();
        chk("retry_k0_cstart", 32'(circ_start), 1);
        chk("retry_colour", 32'(vga_colour), 6);

        // Abort during k=1
        pixel(8'd0, 7'd0, 1'b0, 1'b1);
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        step();
        chk_centre("ab_k1run", 8'd40, 7'd83);
        pixel(8'd100, 7'd50, 1'b1, 1'b0);
        start = 1'b0;
        step();
        chk("ab_crst", 32'(circ_rst_n), 0);
        chk("ab_cstart", 32'(circ_start), 0);
        chk("ab_plot", 32'(vga_plot), 0);
        chk("ab_done", 32'(done), 0);
        step();
        chk("ab_done2", 32'(done), 0);
        pixel(8'd0, 7'd0, 1'b0, 1'b0);

        // Reset during k=2, then redraw from k=0
        set_req(8'd80, 7'd60, 8'd80, 3'd2);
        start = 1'b1;
        step();
        step();
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b1);
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b1);
        step();
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        step();
        chk_centre("rs_k2run", 8'd120, 7'd83);
        chk("rs_k2_cstart", 32'(circ_start), 1);
        rst_n = 1'b0;
        pixel(8'd60, 7'd50, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        pixel(8'd0, 7'd0, 1'b0, 1'b0);
        step();
        chk("rs_calc_cstart", 32'(circ_start), 0);
        step();
        chk_centre("rs_k0rst", 8'd80, 7'd14);
        step();
        chk("rs_k0_cstart", 32'(circ_start), 1);
        chk_centre("rs_k0run", 8'd80, 7'd14);
        chk("rs_colour", 32'(vga_colour), 2);
        start = 1'b0;
        step();
        chk("rs_end_cstart", 32'(circ_start), 0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
